// File: rtl/sram_arb_pkg.sv
//==============================================================================
// Module      : sram_arb_pkg
// Description : Shared encodings and constants for the SRAM port arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package sram_arb_pkg;

    localparam logic [0:0] SRAM_ARB_IDLE = 1'b0;
    localparam logic [0:0] SRAM_ARB_WAIT = 1'b1;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    localparam int unsigned c_rd_lat_min = 1;
    localparam int unsigned c_rd_lat_max = 7;
    localparam int unsigned c_cnt_w      = 3;

endpackage

`default_nettype wire

// File: rtl/sram_arb_pick.sv
//==============================================================================
// Module      : sram_arb_pick
// Description : Combinational grant selector; data wins a contest unless the
//               last-loser flag says inst is owed the port.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sram_arb_pick (
    input  logic inst_req,
    input  logic data_req,
    input  logic port_free,
    input  logic last_loser,
    output logic inst_gnt,
    output logic data_gnt
);

    always_comb begin
        inst_gnt = 1'b0;
        data_gnt = 1'b0;
        if (port_free) begin
            if (inst_req && data_req) begin
                inst_gnt = last_loser;
                data_gnt = ~last_loser;
            end else begin
                inst_gnt = inst_req;
                data_gnt = data_req;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sram_arb.sv
//==============================================================================
// Module      : sram_arb
// Description : Arbiter/sequencer for the shared SRAM port (fetch + data).
//               Define SRAM_ARB_RR_EN for round-robin fairness between them.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sram_arb
    import sram_arb_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_gnt,
    output logic        inst_rvalid,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,
    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    output logic        stallreq
);

    localparam logic [c_cnt_w-1:0] c_rd_lat_cnt = RD_LAT[c_cnt_w-1:0];

    logic [0:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_owner;
    logic [0:0]         w_state_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_owner_nxt;

    logic w_resp;
    logic w_busy;
    logic w_port_free;
    logic w_inst_gnt;
    logic w_data_gnt;
    logic w_last_loser;
    logic w_grant_read;

    // Response cycle frees the port so a new read can overlap the returning one.
    assign w_resp      = (r_state == SRAM_ARB_WAIT) && (r_cnt == c_cnt_w'(1));
    assign w_busy      = (r_state == SRAM_ARB_WAIT) && (r_cnt > c_cnt_w'(1));
    assign w_port_free = ~rst & ~w_busy;

`ifdef SRAM_ARB_RR_EN
    logic r_last_loser;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_loser <= 1'b0;
        end else if (w_inst_gnt) begin
            r_last_loser <= 1'b0;
        end else if (inst_req && w_data_gnt) begin
            r_last_loser <= 1'b1;
        end
    end

    assign w_last_loser = r_last_loser;
`else
    assign w_last_loser = 1'b0;
`endif

    sram_arb_pick u_pick (
        .inst_req   (inst_req),
        .data_req   (data_req),
        .port_free  (w_port_free),
        .last_loser (w_last_loser),
        .inst_gnt   (w_inst_gnt),
        .data_gnt   (w_data_gnt)
    );

    assign inst_gnt     = w_inst_gnt;
    assign data_gnt     = w_data_gnt;
    assign w_grant_read = w_inst_gnt | (w_data_gnt & (data_wen == 4'b0000));

    always_comb begin
        sram_en    = 1'b0;
        sram_wen   = 4'b0000;
        sram_addr  = 32'h0;
        sram_wdata = 32'h0;
        if (w_data_gnt) begin
            sram_en    = 1'b1;
            sram_wen   = data_wen;
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
        end else if (w_inst_gnt) begin
            sram_en    = 1'b1;
            sram_addr  = inst_addr;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_owner_nxt = r_owner;
        if (w_grant_read) begin
            w_state_nxt = SRAM_ARB_WAIT;
            w_cnt_nxt   = c_rd_lat_cnt;
            w_owner_nxt = w_data_gnt ? OWNER_DATA : OWNER_INST;
        end else if (r_state == SRAM_ARB_WAIT) begin
            w_cnt_nxt = r_cnt - c_cnt_w'(1);
            if (w_resp) begin
                w_state_nxt = SRAM_ARB_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SRAM_ARB_IDLE;
            r_cnt   <= '0;
            r_owner <= OWNER_INST;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    assign inst_rvalid = ~rst & w_resp & (r_owner == OWNER_INST);
    assign data_rvalid = ~rst & w_resp & (r_owner == OWNER_DATA);
    assign inst_rdata  = inst_rvalid ? sram_rdata : 32'h0;
    assign data_rdata  = data_rvalid ? sram_rdata : 32'h0;

    assign stallreq = ~rst & ((inst_req & ~w_inst_gnt) | (data_req & ~w_data_gnt) | w_busy);

endmodule

`default_nettype wire

// File: tb/tb_sram_arb.sv
//==============================================================================
// Module      : tb_sram_arb
// Description : Self-checking bench for sram_arb against a cycle-indexed model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sram_arb;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_gnt;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        stallreq;

    always #5 clk = ~clk;

    sram_arb #(.RD_LAT(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_gnt    (inst_gnt),
        .inst_rvalid (inst_rvalid),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_wen    (data_wen),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_gnt    (data_gnt),
        .data_rvalid (data_rvalid),
        .data_rdata  (data_rdata),
        .sram_en     (sram_en),
        .sram_wen    (sram_wen),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata),
        .stallreq    (stallreq)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    endtask

    // Model: one outstanding read remembered by the absolute cycle its data is due.
    bit          m_pend  = 1'b0;
    int          m_due   = 0;
    bit          m_odata = 1'b0;
    bit          m_owed  = 1'b0;
    bit          m_ig_prev = 1'b0;
    bit          m_dg_prev = 1'b0;
    bit          h_i = 1'b0, h_d = 1'b0;
    logic [31:0] h_iaddr, h_daddr, h_dwdata;
    logic [3:0]  h_dwen;

    always @(negedge clk) begin : p_model
        logic        e_ig, e_dg, e_en, e_irv, e_drv, e_stall;
        logic [3:0]  e_wen;
        logic [31:0] e_addr, e_wd, e_ird, e_drd;
        bit          resp_now, busy, inst_first;

        resp_now = m_pend && (m_due == cyc);
        busy     = m_pend && (m_due > cyc);
        e_ig = 0; e_dg = 0; e_en = 0; e_wen = 0; e_addr = 0; e_wd = 0;
        e_irv = 0; e_drv = 0; e_ird = 0; e_drd = 0; e_stall = 0;
        if (!rst) begin
`ifdef SRAM_ARB_RR_EN
            inst_first = m_owed;
`else
            inst_first = 1'b0;
`endif
            if (!busy) begin
                if (inst_req && data_req) begin
                    e_ig = inst_first;
                    e_dg = !inst_first;
                end else begin
                    e_ig = inst_req;
                    e_dg = data_req;
                end
            end
            if (e_dg) begin
                e_en = 1; e_wen = data_wen; e_addr = data_addr; e_wd = data_wdata;
            end else if (e_ig) begin
                e_en = 1; e_addr = inst_addr;
            end
            if (resp_now) begin
                if (m_odata) begin e_drv = 1; e_drd = sram_rdata; end
                else         begin e_irv = 1; e_ird = sram_rdata; end
            end
            e_stall = (inst_req && !e_ig) || (data_req && !e_dg) || busy;
        end

        chk("inst_gnt",    inst_gnt,    e_ig);
        chk("data_gnt",    data_gnt,    e_dg);
        chk("sram_en",     sram_en,     e_en);
        chk("sram_wen",    sram_wen,    e_wen);
        chk("sram_addr",   sram_addr,   e_addr);
        chk("sram_wdata",  sram_wdata,  e_wd);
        chk("inst_rvalid", inst_rvalid, e_irv);
        chk("inst_rdata",  inst_rdata,  e_ird);
        chk("data_rvalid", data_rvalid, e_drv);
        chk("data_rdata",  data_rdata,  e_drd);
        chk("stallreq",    stallreq,    e_stall);

        if (h_i && inst_req && inst_addr !== h_iaddr) begin
            n_checks++;
            $display("FAIL hold_inst cycle %0d: addr 0x%08h changed from 0x%08h", cyc, inst_addr, h_iaddr);
        end
        if (h_d && data_req && {data_addr, data_wdata, data_wen} !== {h_daddr, h_dwdata, h_dwen}) begin
            n_checks++;
            $display("FAIL hold_data cycle %0d: addr 0x%08h changed from 0x%08h", cyc, data_addr, h_daddr);
        end
        h_i = inst_req && !e_ig; h_iaddr = inst_addr;
        h_d = data_req && !e_dg; h_daddr = data_addr; h_dwdata = data_wdata; h_dwen = data_wen;

        if (rst) begin
            m_pend = 0;
            m_owed = 0;
        end else begin
            if (resp_now) m_pend = 0;
            if (e_ig || (e_dg && data_wen == 4'b0000)) begin
                m_pend = 1; m_due = cyc + LAT; m_odata = e_dg;
            end
            if (e_ig) m_owed = 0;
            else if (inst_req && e_dg) m_owed = 1;
        end
        m_ig_prev = e_ig;
        m_dg_prev = e_dg;
        cyc++;
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    initial begin : p_watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin : p_stim
        logic [1:0] rr_exp [4];
        int k, guard;
        bit got_i, got_d;

        rst = 1; inst_req = 0; inst_addr = 0; data_req = 0; data_wen = 0;
        data_addr = 0; data_wdata = 0; sram_rdata = 32'hCAFE_0000;

        neg();
        chk("rst_sram_en", sram_en, 0);
        chk("rst_stallreq", stallreq, 0);
        nxt(); nxt();
        rst = 0;
        neg();
        chk("post_rst_en", sram_en, 0);

        // Inst read alone: stall while waiting, data back after LAT cycles.
        nxt(); inst_req = 1; inst_addr = 32'h0;
        neg(); chk("a_inst_gnt", inst_gnt, 1); chk("a_stall_T", stallreq, 0);
        nxt(); inst_req = 0;
        neg(); chk("a_stall_T1", stallreq, 1);
        nxt();
        neg(); chk("a_stall_T2", stallreq, 1);
        nxt(); sram_rdata = 32'h1234_5678;
        neg(); chk("a_inst_rvalid", inst_rvalid, 1); chk("a_inst_rdata", inst_rdata, 32'h1234_5678);
        chk("a_data_rvalid", data_rvalid, 0);
        nxt();
        neg(); chk("a_idle_stall", stallreq, 0); chk("a_idle_rvalid", inst_rvalid, 0);

        // Data read alone at 0x100.
        nxt(); data_req = 1; data_wen = 0; data_addr = 32'h100;
        neg(); chk("b_data_gnt", data_gnt, 1); chk("b_addr", sram_addr, 32'h100);
        nxt(); data_req = 0;
        repeat (LAT - 2) nxt();
        nxt(); sram_rdata = 32'hDEAD_BEEF;
        neg(); chk("b_data_rvalid", data_rvalid, 1); chk("b_data_rdata", data_rdata, 32'hDEAD_BEEF);
        chk("b_inst_rvalid", inst_rvalid, 0); chk("b_inst_rdata", inst_rdata, 0);

        // Contest: store from data wins, fetch granted next cycle.
        nxt(); data_req = 1; data_wen = 4'b1111; data_addr = 32'h200; data_wdata = 32'h55AA;
        inst_req = 1; inst_addr = 32'h40;
        neg(); chk("c_data_gnt", data_gnt, 1); chk("c_wen", sram_wen, 4'b1111);
        chk("c_wdata", sram_wdata, 32'h55AA); chk("c_inst_gnt", inst_gnt, 0); chk("c_stall", stallreq, 1);
        nxt(); data_req = 0;
        neg(); chk("c_inst_gnt_next", inst_gnt, 1); chk("c_addr_next", sram_addr, 32'h40);
        nxt(); inst_req = 0;
        repeat (LAT) nxt();

        // Back-to-back reads: second grant lands in the first's response cycle.
        data_req = 1; data_wen = 0; data_addr = 32'h10;
        neg(); chk("d_gnt0", data_gnt, 1);
        nxt(); data_addr = 32'h14;
        neg(); chk("d_wait_gnt", data_gnt, 0); chk("d_wait_stall", stallreq, 1);
        repeat (LAT - 2) nxt();
        nxt(); sram_rdata = 32'hAAAA_0010;
        neg(); chk("d_gnt1", data_gnt, 1); chk("d_rvalid0", data_rvalid, 1);
        chk("d_rdata0", data_rdata, 32'hAAAA_0010); chk("d_addr1", sram_addr, 32'h14);
        nxt(); data_req = 0;
        repeat (LAT - 2) nxt();
        nxt(); sram_rdata = 32'hBBBB_0014;
        neg(); chk("d_rvalid1", data_rvalid, 1); chk("d_rdata1", data_rdata, 32'hBBBB_0014);
        nxt();

        // Reset while a read is outstanding drops it.
        data_req = 1; data_wen = 0; data_addr = 32'h300;
        neg(); chk("e_gnt", data_gnt, 1);
        nxt(); data_req = 0; rst = 1;
        neg(); chk("e_rst_rvalid", data_rvalid, 0); chk("e_rst_en", sram_en, 0);
        nxt(); rst = 0;
        neg(); chk("e_after_stall", stallreq, 0); chk("e_after_rvalid", data_rvalid, 0);
        nxt();
        neg(); chk("e_late_rvalid", data_rvalid, 0);
        nxt(); inst_req = 1; inst_addr = 32'h500;
        neg(); chk("e_fresh_gnt", inst_gnt, 1); chk("e_fresh_addr", sram_addr, 32'h500);
        nxt(); inst_req = 0;
        repeat (LAT) nxt();

        // Both requesters held: winners over the first four free cycles.
`ifdef SRAM_ARB_RR_EN
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
`else
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b01; rr_exp[2] = 2'b01; rr_exp[3] = 2'b01;
`endif
        data_req = 1; data_wen = 4'b1111; data_addr = 32'h600; data_wdata = 32'h1;
        inst_req = 1; inst_addr = 32'h700;
        k = 0; guard = 0;
        while (k < 4 && guard < 40) begin
            neg();
            got_i = inst_gnt; got_d = data_gnt;
            if (got_i || got_d) begin
                chk($sformatf("f_win%0d", k), {30'b0, got_i, got_d}, {30'b0, rr_exp[k]});
                k++;
            end
            guard++;
            nxt();
            if (got_d) begin data_addr += 4; data_wdata += 1; end
            if (got_i) inst_addr += 4;
        end
        if (k < 4) chk("f_timeout", k, 4);
        inst_req = 0; data_req = 0;
        repeat (LAT + 1) nxt();

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            sram_rdata = $urandom;
            if (!inst_req || m_ig_prev) begin
                inst_req  = ($urandom_range(0, 2) == 0);
                inst_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!data_req || m_dg_prev) begin
                data_req   = ($urandom_range(0, 1) == 1);
                data_wen   = ($urandom_range(0, 1) == 1) ? 4'b0000 : 4'($urandom);
                data_addr  = $urandom;
                data_wdata = $urandom;
            end
            nxt();
        end

        rst = 0; inst_req = 0; data_req = 0;
        repeat (LAT + 2) nxt();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sram_arb.md
# sram_arb

Arbiter and sequencer for the single shared SRAM port of the CPU, used by the fetch (inst) requester and the memory-access (data) requester. It grants one requester per cycle, drives the SRAM address, enable and write-strobe lines, and tracks an outstanding read until its data returns. It routes the read data back to the owning requester and raises a stall request to the pipeline controller whenever a requester must wait.

## Interface
Parameters:
- RD_LAT, 1, cycles from read issue to valid `sram_rdata`; legal range 1..7.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- inst_req  in  1  fetch requests a read; held until `inst_gnt`.
- inst_addr  in  32  fetch byte address.
- inst_gnt  out  1  fetch request issued to SRAM this cycle.
- inst_rvalid  out  1  `inst_rdata` valid this cycle.
- inst_rdata  out  32  fetch read data.
- data_req  in  1  data access request; held until `data_gnt`.
- data_wen  in  4  byte write strobes; 4'b0000 = read.
- data_addr  in  32  data byte address.
- data_wdata  in  32  store data, already lane-aligned.
- data_gnt  out  1  data request issued this cycle.
- data_rvalid  out  1  `data_rdata` valid this cycle; reads only.
- data_rdata  out  32  data read data.
- sram_en  out  1  SRAM port enable.
- sram_wen  out  4  SRAM byte write strobes.
- sram_addr  out  32  SRAM address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data.
- stallreq  out  1  stall request to the pipeline controller.

## Operation
- States:
  - IDLE: no outstanding read.
  - WAIT: read outstanding. Registers hold owner (INST/DATA) and counter `cnt` (3 bits).
- Port free when state is IDLE, or state is WAIT with `cnt`==1 (response cycle). Reads therefore pipeline back-to-back.
- Grant rule when port free: data wins over inst. At most one grant per cycle. No grant when port not free.
- Granted cycle:
  - `sram_en`=1.
  - `sram_addr`/`sram_wdata`/`sram_wen` come from the winner. Inst always has wen 0.
  - Otherwise `sram_en`=0, `sram_wen`=0, addr/wdata=0.
- Granted read → WAIT with `cnt`=RD_LAT and owner recorded.
- Granted write → completes in its grant cycle. No rvalid, no state change.
- WAIT: `cnt` decrements each cycle.
  - When `cnt`==1, owner's rvalid=1 and its rdata = `sram_rdata` (combinational pass-through).
  - Next state: WAIT (new read granted this cycle), else IDLE.
- Non-owner rdata and all rvalid outside the response cycle are 0.
- `stallreq` = (inst_req & ~inst_gnt) | (data_req & ~data_gnt) | (WAIT & `cnt`>1).
- Requesters changing addr/wdata/wen while `req` is high and not granted: undefined behaviour. The bench flags it.

## Timing
- Reset values: state IDLE, `cnt`=0, owner INST, last-loser flag 0.
  - All outputs 0 in the reset cycle and the cycle after, unless a request is present after reset deasserts.
- Read latency: grant at cycle T → rvalid at T+RD_LAT.
- Write latency: 0; done at grant.
- Simultaneous requests, port free: data granted, inst stalls (`stallreq`=1) and is granted the next free cycle. Data priority can starve fetch only if data requests every free cycle.
- Response cycle + new request: rvalid for the old read and grant for the new one in the same cycle. `stallreq` follows the formula.
- `rst` during WAIT: outstanding read dropped, no rvalid, IDLE next cycle.
- `cnt` never wraps. Loaded only from RD_LAT; decrements only in WAIT.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin fairness.
  - A 1-bit last-loser register is set when inst lost a simultaneous contest and cleared when inst is granted.
  - While set, inst wins the next contest.
- Undefined: fixed data priority. The flag register is absent.

## Structure
- Shared defines file:
  - state encodings `SRAM_ARB_IDLE`/`SRAM_ARB_WAIT`.
  - owner encodings `OWNER_INST`/`OWNER_DATA`.
  - RD_LAT legal-range constants.
- Sub-module `sram_arb_pick`: combinational priority/round-robin selector. Inputs: both reqs, port-free, last-loser flag. Outputs: both grants.
- Counter, state and owner registers stay in `sram_arb`.

## Test plan
- RD_LAT=1, data read @0x100 alone, `sram_rdata`=0xDEADBEEF at T+1 → `data_gnt`@T, `data_rvalid`@T+1 with 0xDEADBEEF, `inst_rvalid`=0, `stallreq`=0.
- RD_LAT=3, inst read @0x0 → `stallreq`=1 @T+1,T+2, `inst_rvalid`@T+3, IDLE @T+4.
- Both req same cycle, data = sw 0x55AA to 0x200, wen 4'b1111 → `data_gnt`, `sram_wen`=4'b1111, `inst_gnt`=0, `stallreq`=1. Next cycle `inst_gnt`=1.
- RD_LAT=2, back-to-back data reads @0x10, 0x14 → second grant in first's response cycle, rvalids @T+2 and T+4.
- `rst` asserted at T+1 of RD_LAT=3 read → no rvalid ever, all outputs 0, fresh grant works after release.
- `SRAM_ARB_RR_EN` defined, both requesters held high for 4 free cycles → grants alternate data, inst, data, inst.
